mac_acc_lanes: RTL and testbench
================================

Name: mac_acc_lanes

Overview:
- Parametrised, multi-lane signed multiply-accumulate engine; successor to the single-channel 32-bit accumulator in Extended_DLX.
- Accumulates a programmed-length burst of packed operand vectors (LANES independent dot-product lanes) and presents the results through a valid/ready handshake.
- Sits beside the DLX datapath as the TinyML vector-MAC unit; the core issues `start`/`len`, streams operands, then reads results.

Parameters:
- LANES, 4, number of parallel MAC lanes.
- DW, 8, signed operand width per lane.
- AW, 32, signed accumulator width per lane; must be >= 2*DW.
- CNT_W, 16, width of burst-length counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin burst; sampled only in IDLE.
- len  in  CNT_W  number of input beats in the burst; latched on start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts beat.
- a  in  LANES*DW  packed signed operands; lane i = bits [i*DW +: DW].
- b  in  LANES*DW  packed signed operands, same packing.
- out_valid  out  1  results available.
- out_ready  in  1  consumer accepts results.
- acc_out  out  LANES*AW  packed signed accumulators, lane i = [i*AW +: AW].
- ovf  out  LANES  per-lane sticky overflow flag, valid with out_valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; all accumulators, counter, `ovf`, `out_valid`, `in_ready` and `busy` = 0.
- States:
  - IDLE: `in_ready`=0, `out_valid`=0.
    - start=1 → clear all accumulators and `ovf` to 0, latch `len` into the counter.
    - Next state is DONE if len==0, else ACCUM.
  - ACCUM: `in_ready`=1. Each beat with in_valid&&in_ready:
    - `acc[i] += sext_AW(a[i]*b[i])`, where the product is a signed 2*DW-bit value.
    - Counter decrements.
    - The beat that takes the counter 1→0 moves the state to DONE.
    - in_valid=0 cycles are stalls; no state change.
  - DONE: `out_valid`=1; `acc_out` and `ovf` held stable.
    - out_valid&&out_ready → IDLE.
    - `out_valid` stays high under backpressure.
- Latency: `out_valid` rises the cycle after the last accepted beat (1 cycle). With len==0 it rises the cycle after start.
- `start` is ignored in ACCUM and DONE. `start` in the same cycle as the DONE→IDLE transition is ignored; it is accepted from IDLE only.
- `acc_out` mirrors the accumulator registers continuously. It is architecturally meaningful only while `out_valid`=1.
- Arithmetic: two's complement.
  - Default (macro off): wrap modulo 2^AW.
  - `ovf[i]` is set sticky when a lane add overflows: operands have the same sign and the result sign differs.
- Lanes are fully independent; overflow in one lane does not affect the others.
- rst mid-burst: immediate return to IDLE, results discarded, no `out_valid`.

Optional Feature:
- Macro: MAC_ACC_SAT_EN.
- Defined: on a signed overflow, the lane accumulator saturates to +(2^(AW-1)-1) or -(2^(AW-1)). `ovf[i]` is still set. Subsequent beats continue from the saturated value.
- Undefined: wrap-around arithmetic as above; no saturation logic is synthesised.

Decomposition:
- Package mac_acc_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - Default values of DW, AW and CNT_W.
  - Helper constants for AW max/min.
- Sub-module mac_lane (one instance per lane, generate loop): product, sign-extend, add, overflow detect, optional saturation, accumulator register with clear/enable.
- The top level holds the FSM, counter and handshake.

Test Plan:
- Basic burst, LANES=4, DW=8, AW=32: len=3, lane0 a=2 b=3 every beat, other lanes a=1 b=1 → acc_out lane0=18, lanes1-3=3; `out_valid` exactly one cycle after the 3rd handshake; ovf=0.
- Signed: len=2, lane0 a=-128 b=127 → lane0=-32512; lane1 a=-1 b=-1 → lane1=2.
- Stalls and backpressure:
  - in_valid toggled 1,0,0,1,1 with len=3 → same result as a contiguous burst.
  - Hold out_ready=0 for 10 cycles → `out_valid`, `acc_out` stable, `in_ready`=0, and a start pulse is ignored.
  - out_ready=1 → IDLE next cycle.
- len=0: start → DONE next cycle; `acc_out` all 0, ovf=0; no beats accepted.
- Overflow, AW=16 instance, len=3, lane0 a=127 b=127 (16129 per beat):
  - Macro off → lane0=-17149 (48387 wrapped), ovf[0]=1, other lanes' ovf=0.
  - Macro on → lane0=32767, ovf[0]=1.
- Reset mid-burst: rst pulsed after 2 of 4 beats → outputs 0 immediately, busy=0; a new start with len=1, a=5 b=5 → lane0=25 with no residue from the aborted burst.

Source files
------------

// File: rtl/mac_acc_pkg.sv
// Shared types and default sizing for the multi-lane MAC engine.
package mac_acc_pkg;

  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefAw    = 32;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  // Full-precision width of a signed DW x DW product.
  function automatic int unsigned prod_width(int unsigned dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane with sticky overflow flag.
// Saturating accumulation is built only when MAC_ACC_SAT_EN is defined.
module mac_lane
  import mac_acc_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc,
  output logic          ovf
);

  localparam int unsigned PW = prod_width(DW);

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] acc_q;
  logic                 add_ovf;
  logic                 ovf_q;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = AW'(prod);
  assign sum      = acc_q + prod_ext;

  // Same-sign operands producing an opposite-sign result is a signed overflow.
  assign add_ovf = (acc_q[AW-1] == prod_ext[AW-1]) && (sum[AW-1] != acc_q[AW-1]);

`ifdef MAC_ACC_SAT_EN
  localparam logic [AW-1:0] AccMax = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] AccMin = {1'b1, {(AW-1){1'b0}}};

  always_comb begin
    acc_d = sum;
    if (add_ovf) begin
      acc_d = acc_q[AW-1] ? AccMin : AccMax;
    end
  end
`else
  assign acc_d = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      acc_q <= acc_d;
      ovf_q <= ovf_q | add_ovf;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/mac_acc_lanes.sv
// Multi-lane signed MAC engine: burst control FSM, beat counter and handshake.
// Build with MAC_ACC_SAT_EN defined for saturating lane accumulators.
module mac_acc_lanes
  import mac_acc_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] a,
  input  logic [LANES*DW-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*AW-1:0] acc_out,
  output logic [LANES-1:0]    ovf,
  output logic                busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr;
  logic             accept;

  assign accept = in_valid && (state_q == StAccum);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr     = 1'b1;
          cnt_d   = len;
          state_d = (len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DW(DW),
      .AW(AW)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en (accept),
      .a  (a[i*DW +: DW]),
      .b  (b[i*DW +: DW]),
      .acc(acc_out[i*AW +: AW]),
      .ovf(ovf[i])
    );
  end

endmodule

// File: tb/tb_mac_acc_lanes.sv
// Randomised and directed bench for mac_acc_lanes: a 32-bit and a 16-bit accumulator
// instance share stimulus and are checked against an arithmetic reference model.
module tb_mac_acc_lanes;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [CNT_W-1:0]    len = '0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic [LANES*DW-1:0] a = '0;
  logic [LANES*DW-1:0] b = '0;

  logic              in_ready32, out_valid32, busy32;
  logic [LANES*32-1:0] acc32;
  logic [LANES-1:0]  ovf32;
  logic              in_ready16, out_valid16, busy16;
  logic [LANES*16-1:0] acc16;
  logic [LANES-1:0]  ovf16;

  mac_acc_lanes #(.LANES(LANES), .DW(DW), .AW(32), .CNT_W(CNT_W)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready32), .a(a), .b(b), .out_valid(out_valid32), .out_ready(out_ready),
    .acc_out(acc32), .ovf(ovf32), .busy(busy32)
  );

  mac_acc_lanes #(.LANES(LANES), .DW(DW), .AW(16), .CNT_W(CNT_W)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready16), .a(a), .b(b), .out_valid(out_valid16), .out_ready(out_ready),
    .acc_out(acc16), .ovf(ovf16), .busy(busy16)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer sums per lane, range-checked against the accumulator width.
  longint              m32[LANES];
  longint              m16[LANES];
  logic [LANES-1:0]    o32, o16;
  logic [LANES*DW-1:0] qa[$];
  logic [LANES*DW-1:0] qb[$];
  bit                  vpat[$];
  int                  stall_pct = 0;

  function automatic longint step(input longint acc, input longint p, input int aw,
                                  output bit o);
    longint mx, mn, s;
    mx = (longint'(1) <<< (aw - 1)) - 1;
    mn = -mx - 1;
    s  = acc + p;
    o  = 1'b0;
    if (s > mx) begin
      o = 1'b1;
`ifdef MAC_ACC_SAT_EN
      s = mx;
`else
      s = s - (longint'(1) <<< aw);
`endif
    end else if (s < mn) begin
      o = 1'b1;
`ifdef MAC_ACC_SAT_EN
      s = mn;
`else
      s = s + (longint'(1) <<< aw);
`endif
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LANES; i++) begin
      m32[i] = 0;
      m16[i] = 0;
    end
    o32 = '0;
    o16 = '0;
  endtask

  task automatic model_beat(input logic [LANES*DW-1:0] va, input logic [LANES*DW-1:0] vb);
    longint p;
    bit     o;
    for (int i = 0; i < LANES; i++) begin
      p = longint'($signed(va[i*DW +: DW])) * longint'($signed(vb[i*DW +: DW]));
      m32[i] = step(m32[i], p, 32, o);
      o32[i] = o32[i] | o;
      m16[i] = step(m16[i], p, 16, o);
      o16[i] = o16[i] | o;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [LANES*32-1:0] e32;
    logic [LANES*16-1:0] e16;
    for (int i = 0; i < LANES; i++) begin
      e32[i*32 +: 32] = m32[i][31:0];
      e16[i*16 +: 16] = m16[i][15:0];
    end
    check({tag, "_acc32"}, acc32, e32);
    check({tag, "_ovf32"}, ovf32, o32);
    check({tag, "_acc16"}, acc16, e16);
    check({tag, "_ovf16"}, ovf16, o16);
  endtask

  // Runs one burst from IDLE using operands queued in qa/qb, then holds off out_ready
  // for bp cycles (with start asserted) before accepting the results.
  task automatic burst(input int n, input int bp);
    int                  i;
    int                  guard;
    bit                  stall;
    logic [LANES*32-1:0] snap;
    model_clear();
    @(negedge clk);
    check("idle_busy", busy32, 1'b0);
    start = 1'b1;
    len   = CNT_W'(n);
    @(posedge clk);
    i = 0;
    guard = 0;
    while (i < n && guard < 1000) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      check("accum_in_ready", {in_ready16, in_ready32}, 2'b11);
      if (vpat.size() > 0) stall = !vpat.pop_front();
      else stall = ($urandom_range(99) < stall_pct);
      if (stall) begin
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
      end else begin
        in_valid = 1'b1;
        a = qa[0];
        b = qb[0];
      end
      @(posedge clk);
      if (!stall) begin
        model_beat(qa.pop_front(), qb.pop_front());
        i++;
      end
    end
    if (i < n) check("beat_timeout", 128'(i), 128'(n));
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("out_valid_lat", {out_valid16, out_valid32}, 2'b11);
    check("done_in_ready", in_ready32, 1'b0);
    check("done_busy", busy32, 1'b1);
    check_outputs("result");
    snap = acc32;
    for (int k = 0; k < bp; k++) begin
      start = 1'b1;
      len   = CNT_W'($urandom_range(5));
      @(negedge clk);
      check("bp_out_valid", out_valid32, 1'b1);
      check("bp_in_ready", in_ready32, 1'b0);
      check("bp_acc_stable", acc32, snap);
    end
    start = 1'b0;
    if (bp > 0) check_outputs("after_bp");
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", {out_valid16, out_valid32}, 2'b00);
    check("release_busy", {busy16, busy32}, 2'b00);
  endtask

  task automatic push_const(input int n, input logic [LANES*DW-1:0] va,
                            input logic [LANES*DW-1:0] vb);
    for (int k = 0; k < n; k++) begin
      qa.push_back(va);
      qb.push_back(vb);
    end
  endtask

  initial begin
    int n;
    // Reset state.
    #2;
    check("rst_acc32", acc32, '0);
    check("rst_acc16", acc16, '0);
    check("rst_flags", {ovf32, ovf16, out_valid32, in_ready32, busy32}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Basic burst.
    push_const(3, {8'd1, 8'd1, 8'd1, 8'd2}, {8'd1, 8'd1, 8'd1, 8'd3});
    burst(3, 0);
    check("basic_l0", acc32[31:0], 128'd18);
    check("basic_l1", acc32[63:32], 128'd3);

    // Signed corner products.
    push_const(2, {8'd0, 8'd0, 8'hFF, 8'h80}, {8'd0, 8'd0, 8'hFF, 8'h7F});
    burst(2, 0);
    check("signed_l0", acc32[31:0], 128'hFFFF_8100);
    check("signed_l1", acc32[63:32], 128'd2);

    // Stall pattern and 10 cycles of backpressure with start pulses.
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    push_const(3, {8'd1, 8'd1, 8'd1, 8'd2}, {8'd1, 8'd1, 8'd1, 8'd3});
    burst(3, 10);
    check("stall_l0", acc32[31:0], 128'd18);

    // Zero-length burst clears state and completes without beats.
    burst(0, 2);
    check("len0_acc", acc32, '0);

    // Overflow on the 16-bit instance.
    push_const(3, {8'd1, 8'd1, 8'd1, 8'd127}, {8'd1, 8'd1, 8'd1, 8'd127});
    burst(3, 0);
`ifdef MAC_ACC_SAT_EN
    check("ovf16_l0", acc16[15:0], 128'h7FFF);
`else
    check("ovf16_l0", acc16[15:0], 128'hBD03);
`endif
    check("ovf16_flags", ovf16, 4'b0001);
    check("ovf32_flags", ovf32, 4'b0000);

    // Randomised bursts with stalls and backpressure.
    stall_pct = 30;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(8);
      for (int k = 0; k < n; k++) begin
        qa.push_back($urandom);
        qb.push_back($urandom);
      end
      burst(n, $urandom_range(4));
    end
    stall_pct = 0;

    // Reset in the middle of a 4-beat burst.
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(4);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      a = {4{8'd7}};
      b = {4{8'd9}};
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_acc", acc32, '0);
    check("midrst_flags", {busy32, out_valid32, in_ready32, ovf32}, '0);
    @(negedge clk);
    rst = 1'b0;
    push_const(1, {8'd0, 8'd0, 8'd0, 8'd5}, {8'd0, 8'd0, 8'd0, 8'd5});
    burst(1, 0);
    check("after_rst_l0", acc32[31:0], 128'd25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
